// File: rtl/hex8_scan.sv
// hex8_scan: 8-digit multiplexed 7-segment driver with a per-frame input snapshot.
// Outputs are registered one cycle behind idx/shadow; shadow reloads only at frame boundaries.
module hex8_scan #(
   parameter int SCAN_DIV = 50000,
   parameter int CNT_W    = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [31:0] data,
   input  logic [7:0]  dot,
   input  logic [7:0]  digit_mask,
   output logic [7:0]  sel,
   output logic [7:0]  seg,
   output logic        frame_done
);
   localparam logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic             active;
   logic [CNT_W-1:0] div_cnt;
   logic [2:0]       idx;
   logic [31:0]      sh_data;
   logic [7:0]       sh_dot;
   logic [7:0]       sh_mask;
   logic             tick;
   logic             lit;
   logic [3:0]       nib;
   assign tick = div_cnt == CNT_W'(SCAN_DIV - 1);
   assign nib  = sh_data[{idx, 2'b00} +: 4];
   // en low forces idle outputs on the same edge that drops active
   assign lit  = active && en && sh_mask[idx];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active     <= 1'b0;
         div_cnt    <= '0;
         idx        <= 3'd0;
         sh_data    <= 32'h0;
         sh_dot     <= 8'h00;
         sh_mask    <= 8'h00;
         sel        <= 8'h00;
         seg        <= 8'hFF;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         sel        <= lit ? 8'b1 << idx : 8'h00;
         seg        <= lit ? {~sh_dot[idx], DEC[nib]} : 8'hFF;
         if (!en) begin
            active  <= 1'b0;
            div_cnt <= '0;
            idx     <= 3'd0;
         end else if (!active) begin
            active                     <= 1'b1;
            div_cnt                    <= '0;
            idx                        <= 3'd0;
            {sh_data, sh_dot, sh_mask} <= {data, dot, digit_mask};
         end else if (tick) begin
            div_cnt <= '0;
            idx     <= idx + 3'd1;
            if (idx == 3'd7) begin
               {sh_data, sh_dot, sh_mask} <= {data, dot, digit_mask};
               frame_done                 <= 1'b1;
            end
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end
endmodule
